// File: rtl/rv32i_pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: stage valids, hold chain, halt/drain FSM, stall watchdog.
// Optional PIPE_PERF_CNT_EN adds stall-cycle and flush-event counters; otherwise the perf ports are tied to zero.
module rv32i_pipeline_ctrl #(
    parameter int FLUSH_CYCLES  = 2,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fetch_valid,
    input  logic        i_alu_force_stall,
    input  logic        i_memoryaccess_stall,
    input  logic        i_writeback_stall,
    input  logic        i_alu_flush,
    input  logic        i_writeback_flush,
    input  logic        i_halt_req,
    output logic        o_fetch_stall,
    output logic        o_fetch_flush,
    output logic        o_decoder_ce,
    output logic        o_alu_ce,
    output logic        o_memoryaccess_ce,
    output logic        o_writeback_ce,
    output logic        o_stall_alu,
    output logic        o_halted,
    output logic        o_stall_timeout,
    output logic [31:0] o_perf_stall_cycles,
    output logic [31:0] o_perf_flush_count
);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT, S_FLUSH} state_t;

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int WW = $clog2(STALL_TIMEOUT + 1);
    localparam logic [WW-1:0] WD_MAX = WW'(STALL_TIMEOUT);

    state_t          state;
    logic [FW-1:0]   fl_cnt;
    logic [WW-1:0]   wd_cnt;
    logic            timeout;
    logic [5:2]      v;
    logic [5:2]      hold;
    logic            trap;
    logic            branch;

    // Each stage holds only if it is occupied and either stalls itself or cannot hand off downstream.
    always_comb begin
        hold[5] = v[5] & i_writeback_stall;
        hold[4] = v[4] & (i_memoryaccess_stall | hold[5]);
        hold[3] = v[3] & (i_alu_force_stall | hold[4]);
        hold[2] = v[2] & hold[3];
    end

    assign trap   = v[5] & i_writeback_flush;
    assign branch = i_alu_flush & v[3] & ~hold[3] & ~trap;

    assign o_fetch_stall     = hold[2] | (state != S_RUN);
    assign o_fetch_flush     = trap | branch | (state == S_FLUSH);
    assign o_stall_alu       = hold[3];
    assign o_decoder_ce      = v[2];
    assign o_alu_ce          = v[3];
    assign o_memoryaccess_ce = v[4];
    assign o_writeback_ce    = v[5];
    assign o_halted          = (state == S_HALT);
    assign o_stall_timeout   = timeout;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v       <= '0;
            state   <= S_RUN;
            fl_cnt  <= '0;
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (trap) begin
                v <= '0;
            end else begin
                v[5] <= hold[5] ? v[5] : (v[4] & ~hold[4]);
                v[4] <= hold[4] ? v[4] : (v[3] & ~hold[3]);
                v[3] <= branch ? 1'b0 : (hold[3] ? v[3] : (v[2] & ~hold[2]));
                v[2] <= branch ? 1'b0 : (hold[2] ? v[2] : (i_fetch_valid & (state == S_RUN)));
            end

            if (trap) begin
                state  <= S_FLUSH;
                fl_cnt <= FW'(FLUSH_CYCLES - 1);
            end else begin
                case (state)
                    S_RUN:   if (i_halt_req) state <= S_DRAIN;
                    S_DRAIN: begin
                        if (!i_halt_req)   state <= S_RUN;
                        else if (v == '0)  state <= S_HALT;
                    end
                    S_HALT:  if (!i_halt_req) state <= S_RUN;
                    S_FLUSH: begin
                        if (fl_cnt == '0) state  <= S_RUN;
                        else              fl_cnt <= fl_cnt - 1'b1;
                    end
                    default: state <= S_RUN;
                endcase
            end

            // Watchdog saturates at the threshold; the flag stays set until reset.
            if (hold[3]) begin
                if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
                if (wd_cnt >= WD_MAX - 1'b1) timeout <= 1'b1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            perf_stall <= '0;
            perf_flush <= '0;
        end else begin
            if (hold[3])        perf_stall <= perf_stall + 32'd1;
            if (trap | branch)  perf_flush <= perf_flush + 32'd1;
        end
    end

    assign o_perf_stall_cycles = perf_stall;
    assign o_perf_flush_count  = perf_flush;
`else
    assign o_perf_stall_cycles = 32'h0;
    assign o_perf_flush_count  = 32'h0;
`endif

endmodule

// File: tb/tb_rv32i_pipeline_ctrl.sv
// Randomized scoreboard bench for rv32i_pipeline_ctrl: an instruction-tag pipeline model predicts every output each cycle.
module tb_rv32i_pipeline_ctrl;

    localparam int FC = 2;
    localparam int ST = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0, alu_force_stall = 1'b0, mem_stall = 1'b0, wb_stall = 1'b0;
    logic        alu_flush = 1'b0, wb_flush = 1'b0, halt_req = 1'b0;
    logic        fetch_stall, fetch_flush, decoder_ce, alu_ce, memoryaccess_ce, writeback_ce;
    logic        stall_alu, halted, stall_timeout;
    logic [31:0] perf_stall_cycles, perf_flush_count;

    always #5 clk = ~clk;

    rv32i_pipeline_ctrl #(.FLUSH_CYCLES(FC), .STALL_TIMEOUT(ST)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_fetch_valid(fetch_valid), .i_alu_force_stall(alu_force_stall),
        .i_memoryaccess_stall(mem_stall), .i_writeback_stall(wb_stall),
        .i_alu_flush(alu_flush), .i_writeback_flush(wb_flush), .i_halt_req(halt_req),
        .o_fetch_stall(fetch_stall), .o_fetch_flush(fetch_flush),
        .o_decoder_ce(decoder_ce), .o_alu_ce(alu_ce),
        .o_memoryaccess_ce(memoryaccess_ce), .o_writeback_ce(writeback_ce),
        .o_stall_alu(stall_alu), .o_halted(halted), .o_stall_timeout(stall_timeout),
        .o_perf_stall_cycles(perf_stall_cycles), .o_perf_flush_count(perf_flush_count)
    );

    typedef struct {
        bit          fstall, fflush, salu, halt, tmo;
        bit [3:0]    ce;
        logic [31:0] pstall, pflush;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: each stage holds an instruction tag (0 = empty).
    int          st[2:5];
    int          next_tag;
    int          mode;      // 0 run, 1 drain, 2 halted, 3 flushing
    int          flush_left;
    int          wd;
    bit          tmo;
    logic [31:0] m_pstall, m_pflush;

    task automatic model_reset();
        for (int k = 2; k <= 5; k++) st[k] = 0;
        mode = 0; flush_left = 0; wd = 0; tmo = 0;
        m_pstall = 0; m_pflush = 0;
    endtask

    task automatic model_step(input bit r);
        bit blk[2:6];
        bit own[2:5];
        int ns[2:5];
        bit trap, br, empty;
        exp_t e;
        own[5] = wb_stall; own[4] = mem_stall; own[3] = alu_force_stall; own[2] = 1'b0;
        blk[6] = 1'b0;
        for (int k = 5; k >= 2; k--) blk[k] = (st[k] != 0) && (own[k] || blk[k+1]);
        trap  = (st[5] != 0) && wb_flush;
        br    = !trap && (st[3] != 0) && !blk[3] && alu_flush;
        empty = (st[2] == 0) && (st[3] == 0) && (st[4] == 0) && (st[5] == 0);

        e.fstall = blk[2] || (mode != 0);
        e.fflush = trap || br || (mode == 3);
        e.salu   = blk[3];
        e.halt   = (mode == 2);
        e.tmo    = tmo;
        e.ce     = {st[5] != 0, st[4] != 0, st[3] != 0, st[2] != 0};
`ifdef PIPE_PERF_CNT_EN
        e.pstall = m_pstall; e.pflush = m_pflush;
`else
        e.pstall = 32'h0;    e.pflush = 32'h0;
`endif
        exp_q.push_back(e);

        if (r) begin
            model_reset();
            return;
        end
        for (int k = 3; k <= 5; k++) ns[k] = blk[k] ? st[k] : (blk[k-1] ? 0 : st[k-1]);
        if (blk[2])                         ns[2] = st[2];
        else if (fetch_valid && mode == 0)  begin next_tag++; ns[2] = next_tag; end
        else                                ns[2] = 0;
        if (br)   begin ns[2] = 0; ns[3] = 0; end
        if (trap) for (int k = 2; k <= 5; k++) ns[k] = 0;

        if (trap) begin
            mode = 3; flush_left = FC;
        end else if (mode == 0) begin
            if (halt_req) mode = 1;
        end else if (mode == 1) begin
            if (!halt_req) mode = 0; else if (empty) mode = 2;
        end else if (mode == 2) begin
            if (!halt_req) mode = 0;
        end else begin
            flush_left--;
            if (flush_left == 0) mode = 0;
        end

        if (blk[3]) begin
            wd = (wd + 1 > ST) ? ST : wd + 1;
            if (wd >= ST) tmo = 1;
            m_pstall = m_pstall + 1;
        end else begin
            wd = 0;
        end
        if (trap || br) m_pflush = m_pflush + 1;
        for (int k = 2; k <= 5; k++) st[k] = ns[k];
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: every cycle presents outputs; compare against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("fetch_stall",   32'(fetch_stall),   32'(e.fstall));
                chk("fetch_flush",   32'(fetch_flush),   32'(e.fflush));
                chk("stage_ce",      32'({writeback_ce, memoryaccess_ce, alu_ce, decoder_ce}), 32'(e.ce));
                chk("stall_alu",     32'(stall_alu),     32'(e.salu));
                chk("halted",        32'(halted),        32'(e.halt));
                chk("stall_timeout", 32'(stall_timeout), 32'(e.tmo));
                chk("perf_stall",    perf_stall_cycles,  e.pstall);
                chk("perf_flush",    perf_flush_count,   e.pflush);
            end
        end
    end

    // Per-phase percentages: fetch, alu stall, mem stall, wb stall, alu flush, wb flush, halt toggle, reset
    int prob[6][8] = '{
        '{100,  0,  0,  0,  0,  0, 0, 0},
        '{ 90, 20, 20, 20,  0,  0, 0, 0},
        '{ 80, 10, 10, 10, 15, 10, 0, 0},
        '{ 90, 10, 10, 10,  5,  3, 5, 0},
        '{ 90,  5, 70, 10,  0,  0, 0, 0},
        '{ 85, 15, 25, 15, 10,  5, 4, 1}
    };

    function automatic bit pick(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    initial begin
        next_tag = 0;
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 250; c++) begin
                bit r;
                @(posedge clk); #1;
                r = (c == 0) || pick(prob[p][7]);
                rst             = r;
                fetch_valid     = pick(prob[p][0]);
                alu_force_stall = pick(prob[p][1]);
                mem_stall       = pick(prob[p][2]);
                wb_stall        = pick(prob[p][3]);
                alu_flush       = pick(prob[p][4]);
                wb_flush        = pick(prob[p][5]);
                if (c == 0) halt_req = 1'b0;
                else if (pick(prob[p][6])) halt_req = ~halt_req;
                model_step(r);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit got timeout expected finish");
        $fatal(1);
    end

endmodule
